stft_bin_accumulator: RTL and testbench
=======================================

Name: stft_bin_accumulator

Overview:
- Multi-channel, frame-counting successor to the single-register accumulator.
- Accumulates a round-robin stream of NCH STFT bin magnitudes over LEN frames, then drains the NCH sums one by one with a valid/acknowledge handshake.
- Sits between the STFT magnitude stage and the spectrogram/feature buffer feeding the network.

Parameters:
- IL, 10: input sample width, signed two's complement.
- OL, 16: accumulator/output width, signed. Must satisfy OL >= IL + ceil(log2(LEN)) for wrap-free operation.
- NCH, 8: number of bins (channels) per frame, >= 2.
- LEN, 16: frames accumulated per result, >= 1.

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  synchronous reset, active-high.
- iCLR  in  1  synchronous restart of the accumulation window.
- iEN  in  1  input sample valid.
- iDATA  in  IL  input sample, signed.
- oREADY  out  1  block accepts input; a sample is taken when iEN & oREADY.
- oEN  out  1  output valid.
- oDATA  out  OL  accumulated sum for bin oCH, signed.
- oCH  out  clog2(NCH)  bin index of oDATA.
- iACK  in  1  downstream accepts oDATA when oEN & iACK.
- oDONE  out  1  one-cycle pulse after the last bin is acknowledged.

Behaviour:
- Reset is synchronous on iRST = 1 and has the highest priority.
  - Outputs: state ACC, oREADY = 1, oEN = 0, oDATA = 0, oCH = 0, oDONE = 0.
  - Internals: bin pointer = 0, frame counter = 0, all NCH accumulators = 0.
- iCLR is second priority; it returns the block to the reset state but does not need to zero the accumulators.
  - If iCLR and iEN are high in the same cycle, iCLR wins and the sample is dropped.
- The state machine has two states, ACC and DRAIN.
- ACC state (oREADY = 1, oEN = 0):
  - On accept: acc[bin] <= sext(iDATA) when frame == 0, otherwise acc[bin] + sext(iDATA).
  - After each accept the bin pointer increments. At NCH-1 it wraps to 0 and the frame counter increments.
  - Accepting bin NCH-1 of frame LEN-1 moves to DRAIN on the next edge and resets both counters to 0.
- DRAIN state (oREADY = 0; iEN is ignored):
  - oEN = 1 starts in the cycle after the final accept. That final accept at cycle N gives oEN = 1, oCH = 0 at cycle N+1.
  - oDATA = acc[oCH] is registered.
  - While iACK = 0, oDATA and oCH hold stable.
  - On oEN & iACK, oCH increments and the next sum appears the next cycle.
  - Acknowledging oCH = NCH-1 sets oEN = 0, oCH = 0, oREADY = 1, state ACC, and pulses oDONE = 1 for exactly one cycle.
- A new window can be accepted in the cycle oDONE is high.
- Arithmetic: inputs are sign-extended to OL bits. The default sum wraps modulo 2^OL.
- LEN = 1: each result equals the last frame's samples.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - Each addition saturates to [-2^(OL-1), 2^(OL-1)-1].
  - An extra output oOVF (1 bit) is added. It is a sticky flag, set when any saturation occurs, cleared by iRST, iCLR or oDONE, reset value 0.
- Undefined: wrapping arithmetic and no oOVF port.

Test Plan:
All scenarios use IL=8, OL=12, NCH=4, LEN=3 unless stated otherwise.
1. Feed bins 1,2,3,4 for 3 frames with iACK = 1 -> outputs 3,6,9,12 on oCH 0..3 in consecutive cycles. The first output appears one cycle after the 12th accept, and oDONE pulses once.
2. All samples -128 -> every oDATA = -384 (12'hE80).
3. Hold iACK = 0 for 5 cycles at oCH = 1 -> oDATA = 6 and oCH = 1 stay stable, oREADY = 0, and iEN pulses are not accepted.
4. After 5 samples, assert iCLR with iEN = 1 in the same cycle, then feed a full window of 2s -> all outputs are 6, and the earlier samples plus the iCLR-cycle sample have no effect.
5. Overflow case (IL=8, OL=9, LEN=4, all 127):
   - Without ACC_SAT_EN -> oDATA = -4 (508 wrapped).
   - With ACC_SAT_EN -> oDATA = 255 and oOVF = 1.
6. Assert iRST during DRAIN at oCH = 2 -> next cycle oEN = 0, oCH = 0, oREADY = 1. A following full window then produces correct sums.

Source files
------------

// File: rtl/stft_bin_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : stft_bin_accumulator
// Description : Accumulates a round-robin stream of NCH STFT bin magnitudes
//               over LEN frames, then drains the NCH sums one per handshake.
//               Optional macro ACC_SAT_EN: saturating adds plus sticky oOVF.
// Revision    : 1.0 - initial release
// ============================================================================
module stft_bin_accumulator #(
    parameter int IL  = 10,
    parameter int OL  = 16,
    parameter int NCH = 8,
    parameter int LEN = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int FW  = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iCLR,
    input  logic                 iEN,
    input  logic [IL-1:0]        iDATA,
    output logic                 oREADY,
    output logic                 oEN,
    output logic [OL-1:0]        oDATA,
    output logic [CHW-1:0]       oCH,
    input  logic                 iACK,
`ifdef ACC_SAT_EN
    output logic                 oOVF,
`endif
    output logic                 oDONE
);

    localparam logic [0:0]     c_ST_ACC   = 1'b0;
    localparam logic [0:0]     c_ST_DRAIN = 1'b1;
    localparam logic [CHW-1:0] c_LAST_CH  = CHW'(NCH - 1);
    localparam logic [CHW-1:0] c_ONE_CH   = CHW'(1);
    localparam logic [FW-1:0]  c_LAST_FR  = FW'(LEN - 1);
    localparam logic [FW-1:0]  c_ONE_FR   = FW'(1);

    logic [0:0]            r_state;
    logic [0:0]            w_stateNext;
    logic [CHW-1:0]        r_bin;
    logic [FW-1:0]         r_frame;
    logic signed [OL-1:0]  r_acc [NCH];
    logic                  r_oEn;
    logic [OL-1:0]         r_oData;
    logic [CHW-1:0]        r_oCh;
    logic                  r_oDone;

    logic                  w_accept;
    logic                  w_lastBin;
    logic                  w_lastFrame;
    logic                  w_lastAck;
    logic [CHW-1:0]        w_chInc;
    logic [OL-1:0]         w_sext;
    logic [OL-1:0]         w_accCur;
    logic [OL-1:0]         w_accNext;

    assign w_accept    = (r_state == c_ST_ACC) && iEN;
    assign w_lastBin   = (r_bin == c_LAST_CH);
    assign w_lastFrame = (r_frame == c_LAST_FR);
    assign w_lastAck   = (r_state == c_ST_DRAIN) && iACK && (r_oCh == c_LAST_CH);
    assign w_chInc     = r_oCh + c_ONE_CH;
    assign w_sext      = {{(OL-IL){iDATA[IL-1]}}, iDATA};
    assign w_accCur    = r_acc[r_bin];

`ifdef ACC_SAT_EN
    localparam logic [OL-1:0] c_MAX = {1'b0, {(OL-1){1'b1}}};
    localparam logic [OL-1:0] c_MIN = {1'b1, {(OL-1){1'b0}}};
    logic [OL:0] w_sum;
    logic        w_sat;
    logic        r_ovf;

    // One extra bit exposes signed overflow as a disagreement of the top two bits.
    assign w_sum = {w_accCur[OL-1], w_accCur} + {w_sext[OL-1], w_sext};
    assign w_sat = (r_frame != '0) && (w_sum[OL] != w_sum[OL-1]);

    always_comb begin
        w_accNext = w_sum[OL-1:0];
        if (r_frame == '0)
            w_accNext = w_sext;
        else if (w_sat)
            w_accNext = w_sum[OL] ? c_MIN : c_MAX;
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iCLR || r_oDone)
            r_ovf <= 1'b0;
        else if (w_accept && w_sat)
            r_ovf <= 1'b1;
    end

    assign oOVF = r_ovf;
`else
    logic [OL-1:0] w_sum;

    assign w_sum     = w_accCur + w_sext;
    assign w_accNext = (r_frame == '0) ? w_sext : w_sum;
`endif

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_ACC:   if (w_accept && w_lastBin && w_lastFrame) w_stateNext = c_ST_DRAIN;
            c_ST_DRAIN: if (w_lastAck) w_stateNext = c_ST_ACC;
            default:    w_stateNext = c_ST_ACC;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= c_ST_ACC;
            r_bin   <= '0;
            r_frame <= '0;
            r_oEn   <= 1'b0;
            r_oData <= '0;
            r_oCh   <= '0;
            r_oDone <= 1'b0;
            for (int i = 0; i < NCH; i++)
                r_acc[i] <= '0;
        end else if (iCLR) begin
            // Frame 0 overwrites each accumulator, so they need no clearing here.
            r_state <= c_ST_ACC;
            r_bin   <= '0;
            r_frame <= '0;
            r_oEn   <= 1'b0;
            r_oData <= '0;
            r_oCh   <= '0;
            r_oDone <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_oDone <= w_lastAck;
            if (w_accept) begin
                r_acc[r_bin] <= w_accNext;
                if (w_lastBin) begin
                    r_bin <= '0;
                    if (w_lastFrame) begin
                        r_frame <= '0;
                        r_oEn   <= 1'b1;
                        r_oCh   <= '0;
                        r_oData <= r_acc[0];
                    end else begin
                        r_frame <= r_frame + c_ONE_FR;
                    end
                end else begin
                    r_bin <= r_bin + c_ONE_CH;
                end
            end
            if ((r_state == c_ST_DRAIN) && iACK) begin
                if (w_lastAck) begin
                    r_oEn   <= 1'b0;
                    r_oCh   <= '0;
                    r_oData <= '0;
                end else begin
                    r_oCh   <= w_chInc;
                    r_oData <= r_acc[w_chInc];
                end
            end
        end
    end

    assign oREADY = (r_state == c_ST_ACC);
    assign oEN    = r_oEn;
    assign oDATA  = r_oData;
    assign oCH    = r_oCh;
    assign oDONE  = r_oDone;

endmodule
`default_nettype wire

// File: tb/tb_stft_bin_accumulator.sv
`default_nettype none
// Directed bench: main instance IL=8 OL=12 NCH=4 LEN=3; second instance IL=8 OL=9 NCH=4 LEN=4 for overflow.
module tb_stft_bin_accumulator;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1, iCLR = 1'b0, iEN = 1'b0, iACK = 1'b0;
    logic [7:0]  iDATA = '0;
    logic        oREADY, oEN, oDONE;
    logic [11:0] oDATA;
    logic [1:0]  oCH;

    logic        bRST = 1'b1, bCLR = 1'b0, bEN = 1'b0, bACK = 1'b0;
    logic [7:0]  bDATA = '0;
    logic        bREADY, bOEN, bDONE;
    logic [8:0]  bODATA;
    logic [1:0]  bOCH;
`ifdef ACC_SAT_EN
    logic        oOVF, bOVF;
`endif

    int nChecks = 0;
    int nErrors = 0;

    always #5 iCLK = ~iCLK;

    stft_bin_accumulator #(.IL(8), .OL(12), .NCH(4), .LEN(3)) dut (
        .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iEN(iEN), .iDATA(iDATA),
        .oREADY(oREADY), .oEN(oEN), .oDATA(oDATA), .oCH(oCH), .iACK(iACK),
`ifdef ACC_SAT_EN
        .oOVF(oOVF),
`endif
        .oDONE(oDONE));

    stft_bin_accumulator #(.IL(8), .OL(9), .NCH(4), .LEN(4)) dutOvf (
        .iCLK(iCLK), .iRST(bRST), .iCLR(bCLR), .iEN(bEN), .iDATA(bDATA),
        .oREADY(bREADY), .oEN(bOEN), .oDATA(bODATA), .oCH(bOCH), .iACK(bACK),
`ifdef ACC_SAT_EN
        .oOVF(bOVF),
`endif
        .oDONE(bDONE));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic feed(input logic [7:0] v);
        iEN   = 1'b1;
        iDATA = v;
        tick();
        iEN   = 1'b0;
    endtask

    // Feeds LEN=3 frames where bin k receives value v[k].
    task automatic feedWindow(input logic [7:0] v0, v1, v2, v3);
        for (int f = 0; f < 3; f++) begin
            feed(v0); feed(v1); feed(v2); feed(v3);
        end
    endtask

    // Acknowledges from channel startCh through 3, checking each sum, then the done pulse.
    task automatic drainFrom(input string tag, input int startCh,
                             input logic [11:0] e0, e1, e2, e3);
        logic [11:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        iACK = 1'b1;
        for (int ch = startCh; ch < 4; ch++) begin
            check({tag, "_oEN"}, 32'(oEN), 32'd1);
            check({tag, "_oCH"}, 32'(oCH), 32'(ch));
            check({tag, "_oDATA"}, 32'(oDATA), 32'(exp[ch]));
            check({tag, "_rdy"}, 32'(oREADY), 32'd0);
            check({tag, "_nodone"}, 32'(oDONE), 32'd0);
            tick();
        end
        iACK = 1'b0;
        check({tag, "_done"}, 32'(oDONE), 32'd1);
        check({tag, "_endEN"}, 32'(oEN), 32'd0);
        check({tag, "_endCH"}, 32'(oCH), 32'd0);
        check({tag, "_endRdy"}, 32'(oREADY), 32'd1);
    endtask

    initial begin
        // Reset
        tick(); tick();
        iRST = 1'b0; bRST = 1'b0;
        check("rst_ready", 32'(oREADY), 32'd1);
        check("rst_oEN", 32'(oEN), 32'd0);
        check("rst_oDATA", 32'(oDATA), 32'd0);
        check("rst_oCH", 32'(oCH), 32'd0);
        check("rst_oDONE", 32'(oDONE), 32'd0);

        // 1: bins 1..4 over 3 frames; first output one cycle after the 12th accept
        feedWindow(8'd1, 8'd2, 8'd3, 8'd4);
        drainFrom("t1", 0, 12'd3, 12'd6, 12'd9, 12'd12);
        tick();
        check("t1_donePulse", 32'(oDONE), 32'd0);

        // 2: all -128 -> -384
        feedWindow(8'h80, 8'h80, 8'h80, 8'h80);
        drainFrom("t2", 0, 12'hE80, 12'hE80, 12'hE80, 12'hE80);

        // 3: stall at oCH=1 while iEN pulses are ignored
        feedWindow(8'd1, 8'd2, 8'd3, 8'd4);
        iACK = 1'b1;
        tick();
        iACK = 1'b0;
        for (int c = 0; c < 5; c++) begin
            iEN   = c[0] ? 1'b0 : 1'b1;
            iDATA = 8'd50;
            tick();
            check("t3_holdCH", 32'(oCH), 32'd1);
            check("t3_holdDATA", 32'(oDATA), 32'd6);
            check("t3_holdRdy", 32'(oREADY), 32'd0);
            check("t3_holdEN", 32'(oEN), 32'd1);
        end
        iEN = 1'b0;
        drainFrom("t3", 1, 12'd3, 12'd6, 12'd9, 12'd12);

        // 4: iCLR with iEN in the same cycle drops the sample and restarts the window
        for (int k = 0; k < 5; k++) feed(8'd7);
        iCLR = 1'b1; iEN = 1'b1; iDATA = 8'd100;
        tick();
        iCLR = 1'b0; iEN = 1'b0;
        check("t4_clrRdy", 32'(oREADY), 32'd1);
        check("t4_clrEN", 32'(oEN), 32'd0);
        feedWindow(8'd2, 8'd2, 8'd2, 8'd2);
        drainFrom("t4", 0, 12'd6, 12'd6, 12'd6, 12'd6);

        // 6: iRST during drain at oCH=2
        feedWindow(8'd1, 8'd2, 8'd3, 8'd4);
        iACK = 1'b1;
        tick(); tick();
        iACK = 1'b0;
        check("t6_atCh2", 32'(oCH), 32'd2);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        check("t6_rstEN", 32'(oEN), 32'd0);
        check("t6_rstCH", 32'(oCH), 32'd0);
        check("t6_rstRdy", 32'(oREADY), 32'd1);
        check("t6_rstDATA", 32'(oDATA), 32'd0);
        feedWindow(8'd5, 8'd5, 8'd5, 8'd5);
        drainFrom("t6", 0, 12'd15, 12'd15, 12'd15, 12'd15);

        // 5: overflow, 16 samples of 127 into 9-bit sums
        for (int k = 0; k < 16; k++) begin
            bEN = 1'b1; bDATA = 8'd127;
            tick();
        end
        bEN = 1'b0;
        bACK = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            check("t5_oEN", 32'(bOEN), 32'd1);
            check("t5_oCH", 32'(bOCH), 32'(ch));
`ifdef ACC_SAT_EN
            check("t5_satDATA", 32'(bODATA), 32'h0FF);
            check("t5_ovf", 32'(bOVF), 32'd1);
`else
            check("t5_wrapDATA", 32'(bODATA), 32'h1FC);
`endif
            tick();
        end
        bACK = 1'b0;
        check("t5_done", 32'(bDONE), 32'd1);
`ifdef ACC_SAT_EN
        tick();
        check("t5_ovfClr", 32'(bOVF), 32'd0);
        check("t1_noOvf", 32'(oOVF), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
